// File: rtl/ninjakun_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ninjakun_pkg
//  Description : Shared constants and state encoding for the NINJAKUN
//                dual-Z80 IO/video bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package ninjakun_pkg;

   // Arbiter state encoding
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GNT  = 1'b1
   } state_t;

   // Default number of cycles the bus strobes are held per access
   localparam int ACC_CYC_DEF = 2;

   // Shared bus widths
   localparam int AW = 16;
   localparam int DW = 8;

endpackage : ninjakun_pkg
`default_nettype wire

// File: rtl/ninjakun_busarb_port.sv
`default_nettype none
// ============================================================================
//  Module      : ninjakun_busarb_port
//  Description : Per-CPU side of the bus arbiter: raw request, served flag,
//                pending/wait generation and the returned read-data register.
//  Revision    : 1.0  initial release
// ============================================================================
module ninjakun_busarb_port
   import ninjakun_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          rd,
   input  logic          wr,
   input  logic          done,     // completion edge of this CPU's access
   input  logic          rd_acc,   // the completing access is a read
   input  logic [DW-1:0] bus_idt,
   output logic          pnd,
   output logic [DW-1:0] id
);

   logic rq;
   logic srv;

   assign rq  = cs & (rd | wr);
   // Pending drives WAIT directly so the CPU stalls in the same cycle it asks
   assign pnd = rq & ~srv;

   // Served flag: remembers that the current Z80 cycle already got its access
   always_ff @(posedge clk) begin
      if (rst)
         srv <= 1'b0;
      else if (!rq)
         srv <= 1'b0;
      else if (done)
         srv <= 1'b1;
   end

   // Read-data return register, only updated by this CPU's completing reads
   always_ff @(posedge clk) begin
      if (rst)
         id <= '0;
      else if (done && rd_acc)
         id <= bus_idt;
   end

endmodule : ninjakun_busarb_port
`default_nettype wire

// File: rtl/ninjakun_busarb.sv
`default_nettype none
// ============================================================================
//  Module      : ninjakun_busarb
//  Description : Round-robin arbiter sharing the IO/video bus between the two
//                Z80 CPUs. One access at a time, the loser is held with WAIT.
//  Revision    : 1.0  initial release
// ============================================================================
module ninjakun_busarb
   import ninjakun_pkg::*;
#(
   parameter int ACC_CYC = ACC_CYC_DEF
)(
   input  logic          CLK24M,
   input  logic          RESET,
   // CPU0
   input  logic          CS0,
   input  logic [AW-1:0] AD0,
   input  logic [DW-1:0] OD0,
   input  logic          RD0,
   input  logic          WR0,
   output logic [DW-1:0] ID0,
   output logic          WAIT0,
   // CPU1
   input  logic          CS1,
   input  logic [AW-1:0] AD1,
   input  logic [DW-1:0] OD1,
   input  logic          RD1,
   input  logic          WR1,
   output logic [DW-1:0] ID1,
   output logic          WAIT1,
   // Shared bus
   output logic [AW-1:0] CPADR,
   output logic [DW-1:0] CPODT,
   input  logic [DW-1:0] CPIDT,
   output logic          CPRED,
   output logic          CPWRT
);

   localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

   state_t        state, state_nxt;
   logic          own, own_nxt;
   logic          last, last_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [AW-1:0] adr_nxt;
   logic [DW-1:0] odt_nxt;
   logic          red_nxt, wrt_nxt;

   logic          pnd0, pnd1;
   logic          done, done0, done1;
   logic          sel, sel_rd, sel_wr;

   assign done  = (state == ST_GNT) && (cnt == CNT_LAST);
   assign done0 = done & ~own;
   assign done1 = done &  own;
   assign WAIT0 = pnd0;
   assign WAIT1 = pnd1;

   ninjakun_busarb_port u_port0 (
      .clk     (CLK24M),
      .rst     (RESET),
      .cs      (CS0),
      .rd      (RD0),
      .wr      (WR0),
      .done    (done0),
      .rd_acc  (CPRED),
      .bus_idt (CPIDT),
      .pnd     (pnd0),
      .id      (ID0)
   );

   ninjakun_busarb_port u_port1 (
      .clk     (CLK24M),
      .rst     (RESET),
      .cs      (CS1),
      .rd      (RD1),
      .wr      (WR1),
      .done    (done1),
      .rd_acc  (CPRED),
      .bus_idt (CPIDT),
      .pnd     (pnd1),
      .id      (ID1)
   );

   // Grant selection: a tie goes to the CPU that was not served last
   always_comb begin
      sel    = (pnd0 & pnd1) ? ~last : pnd1;
      sel_rd = sel ? RD1 : RD0;
      sel_wr = sel ? WR1 : WR0;
   end

   // Next-state and bus register update; write wins when RD and WR both high
   always_comb begin
      state_nxt = state;
      own_nxt   = own;
      last_nxt  = last;
      cnt_nxt   = cnt;
      adr_nxt   = CPADR;
      odt_nxt   = CPODT;
      red_nxt   = CPRED;
      wrt_nxt   = CPWRT;
      case (state)
         ST_IDLE: begin
            if (pnd0 | pnd1) begin
               state_nxt = ST_GNT;
               own_nxt   = sel;
               cnt_nxt   = 4'd0;
               adr_nxt   = sel ? AD1 : AD0;
               odt_nxt   = sel ? OD1 : OD0;
               wrt_nxt   = sel_wr;
               red_nxt   = sel_rd & ~sel_wr;
            end
         end
         ST_GNT: begin
            if (cnt == CNT_LAST) begin
               state_nxt = ST_IDLE;
               last_nxt  = own;
               red_nxt   = 1'b0;
               wrt_nxt   = 1'b0;
            end else begin
               cnt_nxt   = cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            red_nxt   = 1'b0;
            wrt_nxt   = 1'b0;
         end
      endcase
   end

   // State, arbitration and shared-bus registers
   always_ff @(posedge CLK24M) begin
      if (RESET) begin
         state <= ST_IDLE;
         own   <= 1'b0;
         last  <= 1'b1;
         cnt   <= 4'd0;
         CPADR <= '0;
         CPODT <= '0;
         CPRED <= 1'b0;
         CPWRT <= 1'b0;
      end else begin
         state <= state_nxt;
         own   <= own_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         CPADR <= adr_nxt;
         CPODT <= odt_nxt;
         CPRED <= red_nxt;
         CPWRT <= wrt_nxt;
      end
   end

endmodule : ninjakun_busarb
`default_nettype wire

// File: tb/tb_ninjakun_busarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ninjakun_busarb
//  Description : Self-checking bench for ninjakun_busarb. Three instances with
//                ACC_CYC = 1, 2, 4 share one stimulus and are compared against
//                a transaction-level reference model every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ninjakun_busarb;
   import ninjakun_pkg::*;

   localparam int NDUT = 3;

   function automatic int acc_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 4;
   endfunction

   logic          clk = 1'b0;
   logic          rst;
   logic          cs0, rd0, wr0, cs1, rd1, wr1;
   logic [15:0]   ad0, ad1;
   logic [7:0]    od0, od1, cpidt;

   logic [7:0]    id0_o   [NDUT];
   logic [7:0]    id1_o   [NDUT];
   logic          wait0_o [NDUT];
   logic          wait1_o [NDUT];
   logic [15:0]   cpadr_o [NDUT];
   logic [7:0]    cpodt_o [NDUT];
   logic          cpred_o [NDUT];
   logic          cpwrt_o [NDUT];

   int checks   = 0;
   int failures = 0;
   int strobe_cnt [NDUT];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      ninjakun_busarb #(.ACC_CYC((k == 0) ? 1 : (k == 1) ? 2 : 4)) u_dut (
         .CLK24M (clk),
         .RESET  (rst),
         .CS0    (cs0),
         .AD0    (ad0),
         .OD0    (od0),
         .RD0    (rd0),
         .WR0    (wr0),
         .ID0    (id0_o[k]),
         .WAIT0  (wait0_o[k]),
         .CS1    (cs1),
         .AD1    (ad1),
         .OD1    (od1),
         .RD1    (rd1),
         .WR1    (wr1),
         .ID1    (id1_o[k]),
         .WAIT1  (wait1_o[k]),
         .CPADR  (cpadr_o[k]),
         .CPODT  (cpodt_o[k]),
         .CPIDT  (cpidt),
         .CPRED  (cpred_o[k]),
         .CPWRT  (cpwrt_o[k])
      );
   end

   // ---------------- reference model (one access = a countdown) -------------
   bit          m_busy [NDUT];
   int          m_left [NDUT];
   int          m_own  [NDUT];
   int          m_last [NDUT];
   bit          m_isrd [NDUT];
   bit          m_iswr [NDUT];
   bit          m_srv  [NDUT][2];
   logic [7:0]  m_id   [NDUT][2];
   logic [15:0] m_adr  [NDUT];
   logic [7:0]  m_odt  [NDUT];
   bit          rq_s   [2];
   bit          pnd_s  [2];
   int          g;

   always @(posedge clk) begin
      rq_s[0] = cs0 & (rd0 | wr0);
      rq_s[1] = cs1 & (rd1 | wr1);
      for (int k = 0; k < NDUT; k++) begin
         if (rst) begin
            m_busy[k] = 0; m_left[k] = 0; m_own[k] = 0; m_last[k] = 1;
            m_isrd[k] = 0; m_iswr[k] = 0;
            m_srv[k][0] = 0; m_srv[k][1] = 0;
            m_id[k][0] = 8'h00; m_id[k][1] = 8'h00;
            m_adr[k] = 16'h0000; m_odt[k] = 8'h00;
         end else begin
            for (int n = 0; n < 2; n++) pnd_s[n] = rq_s[n] & ~m_srv[k][n];
            for (int n = 0; n < 2; n++) if (!rq_s[n]) m_srv[k][n] = 0;
            if (m_busy[k]) begin
               m_left[k] = m_left[k] - 1;
               if (m_left[k] == 0) begin
                  if (m_isrd[k]) m_id[k][m_own[k]] = cpidt;
                  m_srv[k][m_own[k]] = rq_s[m_own[k]];
                  m_last[k] = m_own[k];
                  m_busy[k] = 0;
               end
            end else if (pnd_s[0] || pnd_s[1]) begin
               if (pnd_s[0] && pnd_s[1]) g = 1 - m_last[k];
               else                      g = pnd_s[0] ? 0 : 1;
               m_own[k]  = g;
               m_busy[k] = 1;
               m_left[k] = acc_of(k);
               m_adr[k]  = (g == 0) ? ad0 : ad1;
               m_odt[k]  = (g == 0) ? od0 : od1;
               m_iswr[k] = (g == 0) ? wr0 : wr1;
               m_isrd[k] = ((g == 0) ? rd0 : rd1) & ~m_iswr[k];
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      bit rq0, rq1;
      rq0 = cs0 & (rd0 | wr0);
      rq1 = cs1 & (rd1 | wr1);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("cpred[%0d]", k), 32'(cpred_o[k]), 32'(m_busy[k] & m_isrd[k]));
         chk($sformatf("cpwrt[%0d]", k), 32'(cpwrt_o[k]), 32'(m_busy[k] & m_iswr[k]));
         chk($sformatf("cpadr[%0d]", k), 32'(cpadr_o[k]), 32'(m_adr[k]));
         chk($sformatf("cpodt[%0d]", k), 32'(cpodt_o[k]), 32'(m_odt[k]));
         chk($sformatf("wait0[%0d]", k), 32'(wait0_o[k]), 32'(rq0 & ~m_srv[k][0]));
         chk($sformatf("wait1[%0d]", k), 32'(wait1_o[k]), 32'(rq1 & ~m_srv[k][1]));
         chk($sformatf("id0[%0d]", k),   32'(id0_o[k]),   32'(m_id[k][0]));
         chk($sformatf("id1[%0d]", k),   32'(id1_o[k]),   32'(m_id[k][1]));
         if (cpred_o[k] === 1'b1 || cpwrt_o[k] === 1'b1) strobe_cnt[k]++;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic clear_strobes();
      for (int k = 0; k < NDUT; k++) strobe_cnt[k] = 0;
   endtask

   task automatic idle_inputs();
      cs0 = 0; rd0 = 0; wr0 = 0; cs1 = 0; rd1 = 0; wr1 = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; idle_inputs();
      ad0 = 16'h0000; ad1 = 16'h0000; od0 = 8'h00; od1 = 8'h00; cpidt = 8'h00;
      tick(2);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_id0[%0d]", k), 32'(id0_o[k]), 32'h0);
         chk($sformatf("rst_adr[%0d]", k), 32'(cpadr_o[k]), 32'h0);
      end
      rst = 0;
      tick(1);

      // 1: single read from CPU0
      clear_strobes();
      cs0 = 1; rd0 = 1; ad0 = 16'hA000; cpidt = 8'h5A;
      tick(8);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s1_width[%0d]", k), 32'(strobe_cnt[k]), 32'(acc_of(k)));
         chk($sformatf("s1_id0[%0d]", k), 32'(id0_o[k]), 32'h5A);
         chk($sformatf("s1_wait1[%0d]", k), 32'(wait1_o[k]), 32'h0);
      end
      idle_inputs(); tick(2);

      // 4: RD and WR both high, write wins and ID0 stays
      clear_strobes();
      cs0 = 1; rd0 = 1; wr0 = 1; ad0 = 16'hA004; od0 = 8'h3C; cpidt = 8'hEE;
      tick(8);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s4_width[%0d]", k), 32'(strobe_cnt[k]), 32'(acc_of(k)));
         chk($sformatf("s4_id0[%0d]", k), 32'(id0_o[k]), 32'h5A);
      end
      idle_inputs(); tick(2);

      // 2: simultaneous after reset, CPU0 write vs CPU1 read
      rst = 1; tick(1); rst = 0;
      clear_strobes();
      cs0 = 1; wr0 = 1; ad0 = 16'hA800; od0 = 8'h11;
      cs1 = 1; rd1 = 1; ad1 = 16'hA001; cpidt = 8'h77;
      tick(1);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s2_first_wr[%0d]", k), 32'(cpwrt_o[k]), 32'h1);
         chk($sformatf("s2_odt[%0d]", k), 32'(cpodt_o[k]), 32'h11);
         chk($sformatf("s2_wait1[%0d]", k), 32'(wait1_o[k]), 32'h1);
      end
      tick(13);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s2_width[%0d]", k), 32'(strobe_cnt[k]), 32'(2 * acc_of(k)));
         chk($sformatf("s2_id1[%0d]", k), 32'(id1_o[k]), 32'h77);
      end
      idle_inputs(); tick(2);

      // 3: round robin, both requesting repeatedly
      for (int r = 0; r < 3; r++) begin
         cs0 = 1; rd0 = 1; ad0 = 16'hA100 + 16'(r);
         cs1 = 1; wr1 = 1; ad1 = 16'hA200 + 16'(r); od1 = 8'(r);
         cpidt = 8'(8'h90 + r);
         tick(14);
         idle_inputs(); tick(1);
      end

      // 5: CPU1 drops its read right after the grant, then re-raises it
      clear_strobes();
      cs1 = 1; rd1 = 1; ad1 = 16'hA0F0; cpidt = 8'hC3;
      tick(1);
      rd1 = 0; tick(6);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s5_width[%0d]", k), 32'(strobe_cnt[k]), 32'(acc_of(k)));
         chk($sformatf("s5_id1[%0d]", k), 32'(id1_o[k]), 32'hC3);
      end
      clear_strobes();
      rd1 = 1; cpidt = 8'h4B; tick(8);
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("s5_reacc[%0d]", k), 32'(strobe_cnt[k]), 32'(acc_of(k)));
      idle_inputs(); tick(2);

      // 6: reset in the middle of an access, then a tie
      cs0 = 1; rd0 = 1; ad0 = 16'hA333; cpidt = 8'hAB;
      tick(2);
      rst = 1; tick(1);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("s6_red[%0d]", k), 32'(cpred_o[k]), 32'h0);
         chk($sformatf("s6_id0[%0d]", k), 32'(id0_o[k]), 32'h0);
         chk($sformatf("s6_id1[%0d]", k), 32'(id1_o[k]), 32'h0);
      end
      rst = 0; idle_inputs(); tick(1);
      cs0 = 1; wr0 = 1; ad0 = 16'hA400; od0 = 8'h21;
      cs1 = 1; wr1 = 1; ad1 = 16'hA401; od1 = 8'h22;
      tick(1);
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("s6_tie_adr[%0d]", k), 32'(cpadr_o[k]), 32'hA400);
      tick(12);
      idle_inputs(); tick(2);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(3) == 0) begin cs0 = 1'($urandom); rd0 = 1'($urandom); wr0 = 1'($urandom); end
         if ($urandom_range(3) == 0) begin cs1 = 1'($urandom); rd1 = 1'($urandom); wr1 = 1'($urandom); end
         ad0 = 16'($urandom); ad1 = 16'($urandom);
         od0 = 8'($urandom);  od1 = 8'($urandom);
         cpidt = 8'($urandom);
         rst = ($urandom_range(149) == 0);
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_ninjakun_busarb
`default_nettype wire
